score_board: RTL and testbench
==============================

// Module: score_board
// PURPOSE
//  Parametrised successor to the two-player score overlay. Holds per-player BCD
//  score counters with increment, clear, saturation and win detection, and
//  renders every player's multi-digit score as 7-segment pixels on the raster.
//  It sits between the ball/goal logic (score_inc pulses) and the video mixer
//  (score_display). Leading zeros are blanked. The winner's score blinks after game over.
// PARAMETERS
//  PLAYERS       2    number of score channels (1..4)
//  DIGITS        2    BCD digits per score (1..3); max score = 10^DIGITS-1
//  WIN_SCORE     11   score that ends the game (1..10^DIGITS-1)
//  BLINK_FRAMES  16   frames per blink half-period in GAME_OVER (>=1)
//  X_BASE        128  left pixel of player 0 score window
//  X_PITCH       192  horizontal distance between player windows
//  Y_TOP         32   top line of all score windows (window height 32)
// PORTS
//  clk            in   1            pixel clock
//  reset_n        in   1            asynchronous reset, active low
//  hpos           in   9            current pixel column
//  vpos           in   9            current line
//  vsync          in   1            vertical sync level; rising edge = new frame
//  score_inc      in   PLAYERS      1-cycle pulse per player: add one point
//  clear_scores   in   1            1-cycle pulse: zero all scores, restart game
//  scores         out  PLAYERS*DIGITS*4  packed BCD, player p at [p*DIGITS*4 +: DIGITS*4]
//  game_over      out  1            high from win until clear_scores or reset
//  winner         out  2            index of winning player, valid while game_over
//  score_display  out  1            registered pixel-on for score overlay
// BEHAVIOUR
//  Reset: all outputs and counters 0; state PLAYING; blink phase on; frame cnt 0.
//  Async assertion clears state at once, mid-frame or mid-increment; release sync to clk.
//  FSM: PLAYING -> GAME_OVER when any score reaches WIN_SCORE (same edge as the incr).
//   GAME_OVER -> PLAYING on clear_scores. No other transitions.
//  Increment: score_inc[p] high at edge N -> scores updated at edge N (visible N+1).
//   BCD ripple: digit 9 -> 0 with carry; at 10^DIGITS-1 the score saturates.
//   Increments ignored in GAME_OVER. Several bits set in one cycle: all apply.
//  clear_scores beats score_inc in the same cycle: scores go 0 and the FSM goes to PLAYING.
//  Simultaneous winners: winner = lowest index reaching WIN_SCORE that cycle.
//  Blink: vsync rising-edge detector (one reg) increments frame cnt, but only in GAME_OVER.
//   Reaching BLINK_FRAMES-1 wraps cnt to 0 and toggles phase. Entering GAME_OVER
//   sets cnt 0 and phase on. Winner's digits are hidden while phase off.
//   The other players' digits stay lit.
//  Geometry: window p spans x in [X_BASE+p*X_PITCH, +DIGITS*32), y in [Y_TOP, Y_TOP+32).
//   Digit d (0 = MSD) occupies cell x offset d*32. The cell-local bits are h[4:2] and v[4:2].
//   Cell decode uses the team segment map (active half h16; a,b,c,d,e,f,g regions).
//  Leading-zero blank: a digit is suppressed if it and all higher digits are 0.
//   The LSD is never suppressed, so score 0 shows "0".
//  Pixel path: combinational decode of (hpos,vpos) -> registered score_display.
//   Latency is exactly 1 clk after hpos/vpos. Outside all windows the output is 0.
//  Overlapping windows (bad params): OR of all players; no error flagged.
// STRUCTURE
//  Package score_pkg: segment-region constants, the CELL=32 constant, and the
//  function bcd_to_seg(4b)->7b, which returns 0 for values above 9.
//  Sub-module bcd_counter #(DIGITS): inc, clr, sat, value out. One instance per player.
//  Top-level holds: FSM, blink timer, winner register, window/digit/segment decode,
//  output register.
// TESTING
//  1 Reset, then raster sweep -> both windows show "0" only (tens blank); game_over=0.
//  2 Nine incs on p0, then 1 more -> scores p0=0x10; "10" drawn. Tens cell x=128..159.
//  3 p1 goes 10 -> 11 -> game_over next cycle, winner=1. Further incs leave p1=0x11.
//  4 p0 and p1 both at 10, incremented the same cycle -> both 11; winner=0.
//  5 GAME_OVER, 16 vsync edges -> p1 pixels off for frames 16..31, on at 32; p0 always on.
//  6 clear_scores with score_inc[0] in the same cycle -> all 0, PLAYING; reset_n pulse mid-line -> display 0 at once.

Source files
------------

// File: rtl/score_pkg.sv
// Shared constants and helpers for the score overlay: cell size, the
// 7-segment region map inside a 32x32 digit cell, and BCD conversions.
package score_pkg;

    localparam int CELL = 32;

    // Segment bit positions inside a 7-bit {a,b,c,d,e,f,g} pattern
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Region rows/cols in 4-pixel units; only the left half (h < 16) is drawn
    localparam logic [2:0] ROW_TOP = 3'd0;
    localparam logic [2:0] ROW_MID = 3'd3;
    localparam logic [2:0] ROW_BOT = 3'd6;
    localparam logic [1:0] COL_L   = 2'd0;
    localparam logic [1:0] COL_R   = 2'd3;

    typedef enum logic {
        PLAYING   = 1'b0,
        GAME_OVER = 1'b1
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    // Elaboration-time conversion of a binary constant to 3 BCD digits
    function automatic logic [11:0] bin_to_bcd(input int val);
        logic [11:0] r;
        int          v;
        r = '0;
        v = val;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Is cell-local block (hx, vy) covered by any lit segment of seg?
    function automatic logic seg_pixel(input logic [6:0] seg,
                                       input logic [2:0] hx,
                                       input logic [2:0] vy);
        logic       on;
        logic [1:0] col;
        logic       upper;
        logic       lower;
        col   = hx[1:0];
        upper = (vy <= ROW_MID);
        lower = (vy >= ROW_MID) && (vy <= ROW_BOT);
        on    = 1'b0;
        if (!hx[2]) begin
            if (seg[SEG_A] && vy == ROW_TOP)          on = 1'b1;
            if (seg[SEG_G] && vy == ROW_MID)          on = 1'b1;
            if (seg[SEG_D] && vy == ROW_BOT)          on = 1'b1;
            if (seg[SEG_F] && col == COL_L && upper)  on = 1'b1;
            if (seg[SEG_B] && col == COL_R && upper)  on = 1'b1;
            if (seg[SEG_E] && col == COL_L && lower)  on = 1'b1;
            if (seg[SEG_C] && col == COL_R && lower)  on = 1'b1;
        end
        return on;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD counter with clear, saturating increment and a look-ahead
// of the value it will hold after the next edge.
module bcd_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inc,
    input  logic                  clr,
    output logic [DIGITS*4-1:0]   value,
    output logic [DIGITS*4-1:0]   value_nxt
);

    logic sat;
    logic carry;

    // Saturated when every digit is 9
    always_comb begin
        sat = 1'b1;
        for (int d = 0; d < DIGITS; d++)
            if (value[d*4 +: 4] != 4'd9) sat = 1'b0;
    end

    // Clear wins; otherwise ripple a +1 up from the least significant digit
    always_comb begin
        value_nxt = value;
        carry     = 1'b1;
        if (clr) begin
            value_nxt = '0;
        end else if (inc && !sat) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (carry) begin
                    if (value[d*4 +: 4] == 4'd9) begin
                        value_nxt[d*4 +: 4] = 4'd0;
                    end else begin
                        value_nxt[d*4 +: 4] = value[d*4 +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) value <= '0;
        else          value <= value_nxt;
    end

endmodule

// File: rtl/score_board.sv
// Per-player BCD scores with win detection, game-over blink and a
// 7-segment raster overlay (registered, one clock after hpos/vpos).
module score_board
    import score_pkg::*;
#(
    parameter int PLAYERS      = 2,
    parameter int DIGITS       = 2,
    parameter int WIN_SCORE    = 11,
    parameter int BLINK_FRAMES = 16,
    parameter int X_BASE       = 128,
    parameter int X_PITCH      = 192,
    parameter int Y_TOP        = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [8:0]                   hpos,
    input  logic [8:0]                   vpos,
    input  logic                         vsync,
    input  logic [PLAYERS-1:0]           score_inc,
    input  logic                         clear_scores,
    output logic [PLAYERS*DIGITS*4-1:0]  scores,
    output logic                         game_over,
    output logic [1:0]                   winner,
    output logic                         score_display
);

    localparam logic [11:0]         WIN_BCD  = bin_to_bcd(WIN_SCORE);
    localparam logic [DIGITS*4-1:0] WIN_VAL  = WIN_BCD[DIGITS*4-1:0];
    localparam int                  CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    state_t                               state, state_nxt;
    logic [PLAYERS-1:0][DIGITS*4-1:0]     val, val_nxt;
    logic [PLAYERS-1:0]                   inc_en;
    logic                                 win_hit;
    logic [1:0]                           win_idx;
    logic                                 enter_over;
    logic                                 vsync_q;
    logic                                 vsync_rise;
    logic [CNT_W-1:0]                     frame_cnt;
    logic                                 phase;
    logic                                 pix;
    logic                                 lead;
    logic                                 lit;
    logic [3:0]                           digit;
    logic [11:0]                          hx_off;
    logic [11:0]                          vy_off;

    assign inc_en     = state == PLAYING ? score_inc : '0;
    assign scores     = val;
    assign game_over  = (state == GAME_OVER);
    assign vsync_rise = vsync & ~vsync_q;
    assign enter_over = (state == PLAYING) && (state_nxt == GAME_OVER);

    for (genvar p = 0; p < PLAYERS; p++) begin : g_cnt
        bcd_counter #(.DIGITS(DIGITS)) u_cnt (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc       (inc_en[p]),
            .clr       (clear_scores),
            .value     (val[p]),
            .value_nxt (val_nxt[p])
        );
    end

    // Lowest-index player whose score lands on WIN_SCORE this cycle
    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        for (int p = PLAYERS - 1; p >= 0; p--) begin
            if (inc_en[p] && val_nxt[p] == WIN_VAL) begin
                win_hit = 1'b1;
                win_idx = 2'(p);
            end
        end
    end

    // Game state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= PLAYING;
        else          state <= state_nxt;
    end

    // Next state: a win ends play unless a clear lands on the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            PLAYING:   if (!clear_scores && win_hit) state_nxt = GAME_OVER;
            GAME_OVER: if (clear_scores)             state_nxt = PLAYING;
            default:   state_nxt = PLAYING;
        endcase
    end

    // Winner is latched on the edge that ends the game
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          winner <= '0;
        else if (enter_over)   winner <= win_idx;
        else if (clear_scores) winner <= '0;
    end

    // Frame counter and blink phase, advancing on vsync rise only after a win
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q   <= 1'b0;
            frame_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            vsync_q <= vsync;
            if (enter_over) begin
                frame_cnt <= '0;
                phase     <= 1'b1;
            end else if (state == GAME_OVER && vsync_rise) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Raster decode: OR of every visible digit cell of every player
    always_comb begin
        pix    = 1'b0;
        lead   = 1'b1;
        lit    = 1'b0;
        digit  = '0;
        hx_off = '0;
        vy_off = {3'b000, vpos} - 12'(Y_TOP);
        for (int p = 0; p < PLAYERS; p++) begin
            lead = 1'b1;
            for (int d = 0; d < DIGITS; d++) begin
                digit = val[p][(DIGITS-1-d)*4 +: 4];
                if (digit != 4'd0) lead = 1'b0;
                hx_off = {3'b000, hpos} - 12'(X_BASE + p*X_PITCH + d*CELL);
                lit = (!lead || d == DIGITS - 1) &&
                      !(game_over && winner == 2'(p) && !phase);
                if (lit && hx_off < 12'(CELL) && vy_off < 12'(CELL))
                    pix = pix | seg_pixel(bcd_to_seg(digit), hx_off[4:2], vy_off[4:2]);
            end
        end
    end

    // Output pixel register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) score_display <= 1'b0;
        else          score_display <= pix;
    end

endmodule

// File: tb/tb_score_board.sv
// Scoreboard bench for score_board: a behavioural model predicts scores,
// game state and overlay pixels; pixel predictions are queued when hpos/vpos
// are driven and popped one clock later when the registered output appears.
module tb_score_board;

    localparam int WIN = 11;
    localparam int BF  = 16;
    localparam int XB  = 128;
    localparam int XP  = 192;
    localparam int YT  = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  hpos = '0;
    logic [8:0]  vpos = '0;
    logic        vsync = 1'b0;
    logic [1:0]  score_inc = '0;
    logic        clear_scores = 1'b0;
    logic [15:0] scores;
    logic        game_over;
    logic [1:0]  winner;
    logic        score_display;

    score_board #(
        .PLAYERS(2), .DIGITS(2), .WIN_SCORE(WIN), .BLINK_FRAMES(BF),
        .X_BASE(XB), .X_PITCH(XP), .Y_TOP(YT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .hpos          (hpos),
        .vpos          (vpos),
        .vsync         (vsync),
        .score_inc     (score_inc),
        .clear_scores  (clear_scores),
        .scores        (scores),
        .game_over     (game_over),
        .winner        (winner),
        .score_display (score_display)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int m_score [2];
    bit m_over;
    int m_win;
    bit m_phase;
    int m_cnt;
    bit exp_q [$];

    // abcdefg patterns for 0..9
    bit [6:0] font [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    // probe points in 4-pixel blocks: a, g, d, b, c, f, e, right half, bottom row
    int pc [9] = '{1, 1, 1, 3, 3, 0, 0, 5, 1};
    int pr [9] = '{0, 3, 6, 1, 5, 1, 5, 2, 7};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int to_bcd(input int s);
        return (s / 10) * 16 + (s % 10);
    endfunction

    function automatic bit exp_pix(input int h, input int v);
        bit       r;
        bit       shown;
        bit [6:0] sg;
        int       s, dig, lx, ly, col, row;
        r = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < 2; d++) begin
                s     = m_score[p];
                dig   = (d == 0) ? s / 10 : s % 10;
                shown = (d == 1) || (s >= 10);
                if (m_over && m_win == p && !m_phase) shown = 1'b0;
                lx = h - (XB + p*XP + d*32);
                ly = v - YT;
                if (shown && lx >= 0 && lx < 32 && ly >= 0 && ly < 32) begin
                    col = lx / 4;
                    row = ly / 4;
                    sg  = font[dig];
                    if (col < 4) begin
                        if (sg[6] && row == 0) r = 1'b1;
                        if (sg[0] && row == 3) r = 1'b1;
                        if (sg[3] && row == 6) r = 1'b1;
                        if (sg[1] && col == 0 && row <= 3) r = 1'b1;
                        if (sg[5] && col == 3 && row <= 3) r = 1'b1;
                        if (sg[2] && col == 0 && row >= 3 && row <= 6) r = 1'b1;
                        if (sg[4] && col == 3 && row >= 3 && row <= 6) r = 1'b1;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic drive_pix(input int h, input int v);
        @(negedge clk);
        if (exp_q.size() > 0) chk("pixel", 32'(score_display), 32'(exp_q.pop_front()));
        hpos = 9'(h);
        vpos = 9'(v);
        exp_q.push_back(exp_pix(h, v));
    endtask

    task automatic sweep();
        for (int p = 0; p < 2; p++)
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 9; k++)
                    drive_pix(XB + p*XP + d*32 + pc[k]*4 + 1, YT + pr[k]*4 + 1);
        drive_pix(127, YT + 5);
        drive_pix(200, YT + 5);
        drive_pix(XB + 13, YT - 1);
        drive_pix(XB + 13, YT + 32);
        @(negedge clk);
        if (exp_q.size() > 0) chk("pixel", 32'(score_display), 32'(exp_q.pop_front()));
    endtask

    task automatic model_reset();
        m_score[0] = 0; m_score[1] = 0;
        m_over = 1'b0; m_win = 0; m_phase = 1'b1; m_cnt = 0;
    endtask

    task automatic step(input logic [1:0] inc, input bit clr);
        @(negedge clk);
        score_inc    = inc;
        clear_scores = clr;
        if (clr) begin
            m_score[0] = 0; m_score[1] = 0; m_over = 1'b0;
        end else if (!m_over) begin
            for (int p = 0; p < 2; p++)
                if (inc[p] && m_score[p] < 99) m_score[p]++;
            for (int p = 1; p >= 0; p--)
                if (inc[p] && m_score[p] == WIN) begin
                    m_over = 1'b1; m_win = p; m_cnt = 0; m_phase = 1'b1;
                end
        end
        @(negedge clk);
        score_inc    = '0;
        clear_scores = 1'b0;
        chk("score p0", 32'(scores[7:0]),  32'(to_bcd(m_score[0])));
        chk("score p1", 32'(scores[15:8]), 32'(to_bcd(m_score[1])));
        chk("game_over", 32'(game_over), 32'(m_over));
        if (m_over) chk("winner", 32'(winner), 32'(m_win));
    endtask

    task automatic vs_pulse();
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
        if (m_over) begin
            if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = !m_phase; end
            else m_cnt++;
        end
    endtask

    initial begin
        model_reset();
        // 1: reset state, then "0" in each window with blank tens
        repeat (3) @(negedge clk);
        chk("rst scores", 32'(scores), 32'h0);
        chk("rst game_over", 32'(game_over), 32'h0);
        chk("rst winner", 32'(winner), 32'h0);
        chk("rst display", 32'(score_display), 32'h0);
        reset_n = 1'b1;
        sweep();

        // 2: p0 counts through 9 to 10
        repeat (9) step(2'b01, 1'b0);
        step(2'b01, 1'b0);
        sweep();

        // 3: p1 to 11 wins; later increments are ignored
        repeat (11) step(2'b10, 1'b0);
        repeat (2) step(2'b11, 1'b0);
        sweep();

        // 5: blink of the winner across frame boundaries
        repeat (15) vs_pulse();
        sweep();
        vs_pulse();
        sweep();
        repeat (16) vs_pulse();
        sweep();

        // 6a: clear beats a simultaneous increment
        step(2'b01, 1'b1);
        sweep();

        // 4: simultaneous winners, lowest index wins
        repeat (10) step(2'b11, 1'b0);
        step(2'b11, 1'b0);
        sweep();

        // 6b: asynchronous reset mid-line clears the lit pixel at once
        drive_pix(XB + 13, YT + 5);
        @(negedge clk);
        chk("pixel pre-reset", 32'(score_display), 32'(exp_q.pop_front()));
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async display", 32'(score_display), 32'h0);
        chk("async scores", 32'(scores), 32'h0);
        chk("async game_over", 32'(game_over), 32'h0);
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        step(2'b01, 1'b0);
        sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
